jam_cost_arb: RTL

- Round-robin arbiter sharing the single cost-ROM read port (W/J address out, 7-bit Cost in) among NREQ job-assignment evaluation lanes.
- Each lane requests one (worker, job) cost at a time. The block registers the granted address onto W/J, tracks the ROM's one-cycle registered-address latency, and returns the cost tagged with the requester ID.
- Sits between the evaluation lanes and the cost ROM, so several permutation evaluators can run in parallel against one ROM.

---
 rtl/jam_cost_arb_if.sv | 32 +++
 rtl/jam_cost_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/jam_cost_arb_if.sv
// Lane-side bus of the cost-ROM arbiter.
//   req      per-lane request, held with its address until granted
//   req_w    per-lane worker index, lane i at [3i+2:3i]
//   req_j    per-lane job index, same packing as req_w
//   lock     per-lane burst lock (only honoured when JAM_ARB_LOCK_EN is defined)
//   gnt      one-hot grant, combinational
//   rsp_*    response: valid/id registered, cost passed through from the ROM
//   busy     an accepted request is still waiting for its response
interface jam_cost_arb_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);
   logic [NREQ-1:0]   req;
   logic [3*NREQ-1:0] req_w;
   logic [3*NREQ-1:0] req_j;
   logic [NREQ-1:0]   lock;
   logic [NREQ-1:0]   gnt;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [6:0]        rsp_cost;
   logic              busy;

   modport master (
      output req, req_w, req_j, lock,
      input  gnt, rsp_valid, rsp_id, rsp_cost, busy
   );

   modport slave (
      input  req, req_w, req_j, lock,
      output gnt, rsp_valid, rsp_id, rsp_cost, busy
   );
endinterface

// File: rtl/jam_cost_arb.sv
// Round-robin arbiter sharing one cost-ROM read port among NREQ lanes.
// The granted lane's (worker, job) is registered onto W/J; the ROM registers
// that address, so Cost is valid two cycles after the accept, and it is
// returned tagged with the requester id.
// Optional macro JAM_ARB_LOCK_EN: a lane granted with lock high keeps the
// port exclusively until it drops lock (row bursts).
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   bus       lane-side jam_cost_arb_if (slave)
//   W, J      registered ROM address
//   Cost      ROM data, valid the cycle after the ROM samples W/J
module jam_cost_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic                CLK,
   input  logic                RST,
   jam_cost_arb_if.slave       bus,
   output logic [2:0]          W,
   output logic [2:0]          J,
   input  logic [6:0]          Cost
);

   localparam int unsigned AW = 3;

   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  gnt_id;
   logic [IDW-1:0]  idx;
   logic            gnt_vld;
   logic [NREQ-1:0] gnt_c;
   logic            s1_valid;
   logic [IDW-1:0]  s1_id;
   logic            rsp_valid_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [AW-1:0]   lane_w [NREQ];
   logic [AW-1:0]   lane_j [NREQ];

   function automatic logic [IDW-1:0] nxt_ptr(input logic [IDW-1:0] k);
      return IDW'((32'(k) + 32'd1) % NREQ);
   endfunction

   // Unpack per-lane addresses
   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign lane_w[g] = bus.req_w[AW*g +: AW];
      assign lane_j[g] = bus.req_j[AW*g +: AW];
   end

`ifdef JAM_ARB_LOCK_EN
   logic            own_vld;
   logic [IDW-1:0]  own_id;
`else
   logic            unused_lock;
   assign unused_lock = ^bus.lock;
`endif

   // Pick the first request at or after the pointer, wrapping around
   always_comb begin
      gnt_c   = '0;
      gnt_id  = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int unsigned n = 0; n < NREQ; n++) begin
         idx = IDW'((32'(ptr) + n) % NREQ);
         if (!gnt_vld && bus.req[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx;
         end
      end
`ifdef JAM_ARB_LOCK_EN
      // A locked owner excludes everyone else, even while it is idle
      if (own_vld && bus.lock[own_id]) begin
         gnt_vld = bus.req[own_id];
         gnt_id  = own_id;
      end
`endif
      if (RST) begin
         gnt_vld = 1'b0;
      end
      if (gnt_vld) begin
         gnt_c[gnt_id] = 1'b1;
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_cost  = Cost;
   assign bus.busy      = s1_valid | rsp_valid_q;

   // Address register, response pipeline and arbitration state
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr         <= '0;
         W           <= '0;
         J           <= '0;
         s1_valid    <= 1'b0;
         s1_id       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
`ifdef JAM_ARB_LOCK_EN
         own_vld     <= 1'b0;
         own_id      <= '0;
`endif
      end else begin
         s1_valid    <= gnt_vld;
         rsp_valid_q <= s1_valid;
         rsp_id_q    <= s1_id;
         if (gnt_vld) begin
            ptr   <= nxt_ptr(gnt_id);
            s1_id <= gnt_id;
            W     <= lane_w[gnt_id];
            J     <= lane_j[gnt_id];
         end
`ifdef JAM_ARB_LOCK_EN
         // Release first so a grant in the same cycle can take ownership
         if (own_vld && !bus.lock[own_id]) begin
            own_vld <= 1'b0;
            if (!gnt_vld) begin
               ptr <= nxt_ptr(own_id);
            end
         end
         if (gnt_vld && bus.lock[gnt_id]) begin
            own_vld <= 1'b1;
            own_id  <= gnt_id;
         end
`endif
      end
   end

endmodule
